channel_sampler: RTL
====================

CHANNEL_SAMPLER -- requirements
Module: channel_sampler

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent input channels (1..16).
REQ-002 Parameter SMPLS_PER_WORD, default 4, samples per channel packed into one output word (2..16).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (2..4).
REQ-004 Port clk  input  1  sole clock; all flops on posedge clk.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port ch_in  input  NUM_CH  asynchronous channel inputs.
REQ-007 Port en  input  1  capture enable; low discards any partial word.
REQ-008 Port smpl_en  input  1  sample strobe; one sample per channel taken on each clk edge where smpl_en and en are both high.
REQ-009 Port smpl  output  NUM_CH*SMPLS_PER_WORD  packed sample word.
REQ-010 Port smpl_vld  output  1  smpl holds an unconsumed word.
REQ-011 Port smpl_rdy  input  1  consumer accepts smpl when smpl_vld and smpl_rdy are both high.
REQ-012 Port ovfl  output  1  sticky flag: a completed word was dropped.
REQ-013 Port clr_ovfl  input  1  clears ovfl.

Function
REQ-014 Each ch_in bit passes through SYNC_STAGES flops clocked every clk; the last stage is the synced value, SYNC_STAGES cycles behind ch_in.
REQ-015 On each capture edge (smpl_en & en), each channel's synced value shifts into a per-channel history of SMPLS_PER_WORD entries, and the sample counter increments.
REQ-016 The sample counter runs 0..SMPLS_PER_WORD-1; the capture that takes the count from SMPLS_PER_WORD-1 to 0 completes a word.
REQ-017 Packing: smpl bit [a*NUM_CH + c] = channel c, sample age index a, where a=0 is the oldest sample in the word and a=SMPLS_PER_WORD-1 is the newest.
REQ-018 Latency: smpl and smpl_vld update on the clk edge following the completing capture edge.
REQ-019 smpl is stable while smpl_vld is high and not accepted.
REQ-020 Accept with no new completion: smpl_vld falls next cycle.
REQ-021 Completion while smpl_vld is low, or in the same cycle as an accept: new word loads and smpl_vld stays or goes high; no overflow.
REQ-022 Completion while smpl_vld is high and not accepted: the new word is dropped, smpl keeps the old word, and ovfl sets next cycle.
REQ-023 clr_ovfl clears ovfl next cycle; a simultaneous set has priority over the clear.
REQ-024 When en is low, the counter returns to 0 next cycle and history contents are don't-care. A pending smpl/smpl_vld is unaffected and the handshake still operates.
REQ-025 smpl_en with en low has no effect.

Reset
REQ-026 During rst, the synchronizer flops, history and smpl go to 0, the counter goes to 0, and smpl_vld and ovfl go to 0.
REQ-027 rst mid-word discards the partial word and any pending word; the first capture after rst deasserts is age index 0 of a fresh word.

Structure
REQ-028 Package channel_sampler_pkg holds the default parameter constants and a function computing the counter width, $clog2(SMPLS_PER_WORD).
REQ-029 One sub-module, ch_sync (a SYNC_STAGES-deep single-bit synchronizer), is instantiated NUM_CH times by generate; the rest is flat.
REQ-030 Parameter legality (ranges in REQ-001..003) is checked at elaboration.

Verification (NUM_CH=2, SMPLS_PER_WORD=4, SYNC_STAGES=2)
REQ-031 Basic packing: smpl_en=1 and en=1 continuously; synced ch0=1,0,1,1 and ch1=0,0,1,0 (oldest first); smpl_rdy=1 -> smpl=8'h71 and smpl_vld high for exactly one cycle, on the cycle after the 4th capture.
REQ-032 Strobe gating: smpl_en pulsed every 3rd cycle with ch_in constant 2'b11 -> first word 8'hFF appears only after the 4th strobe; no word is emitted between strobes.
REQ-033 Back-pressure: smpl_rdy=0 across two word completions -> smpl keeps the first word, ovfl=1; clr_ovfl pulse -> ovfl=0 next cycle; then smpl_rdy=1 -> the first word is accepted once.
REQ-034 Simultaneous events: accept in the same cycle as the next completion -> smpl_vld stays 1 and the new word is loaded, ovfl=0. Also, set and clr_ovfl in the same cycle -> ovfl=1.
REQ-035 Abort and reset: en drops after 2 captures, then restores -> the next word is built from 4 fresh captures. rst asserted mid-word with smpl_vld=1 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/channel_sampler_pkg.sv
// Shared defaults and helpers for the channel sampler.
// Default parameter values and the sample-counter width function.

package channel_sampler_pkg;

   localparam int unsigned DefNumCh        = 2;
   localparam int unsigned DefSmplsPerWord = 4;
   localparam int unsigned DefSyncStages   = 2;

   // Width of a counter that runs 0..smpls-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned smpls);
      return (smpls < 2) ? 1 : $clog2(smpls);
   endfunction

endpackage

// File: rtl/ch_sync.sv
// Single-bit multi-flop synchronizer for one asynchronous channel input.
// Output is the last flop, STAGES cycles behind the input.

module ch_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/channel_sampler.sv
// Multi-channel sampler: synchronizes inputs, packs strobed samples into words,
// and hands them out over a valid/ready handshake with a sticky overflow flag.

module channel_sampler
   import channel_sampler_pkg::*;
#(
   parameter int unsigned NUM_CH         = DefNumCh,
   parameter int unsigned SMPLS_PER_WORD = DefSmplsPerWord,
   parameter int unsigned SYNC_STAGES    = DefSyncStages
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CH-1:0]                ch_in,
   input  logic                             en,
   input  logic                             smpl_en,
   output logic [NUM_CH*SMPLS_PER_WORD-1:0] smpl,
   output logic                             smpl_vld,
   input  logic                             smpl_rdy,
   output logic                             ovfl,
   input  logic                             clr_ovfl
);

   localparam int unsigned W    = NUM_CH * SMPLS_PER_WORD;
   localparam int unsigned CntW = cnt_width(SMPLS_PER_WORD);
   localparam logic [CntW-1:0] CntMax = CntW'(SMPLS_PER_WORD - 1);

   if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("channel_sampler: NUM_CH must be 1..16");
   end
   if (SMPLS_PER_WORD < 2 || SMPLS_PER_WORD > 16) begin : g_bad_smpls
      $error("channel_sampler: SMPLS_PER_WORD must be 2..16");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("channel_sampler: SYNC_STAGES must be 2..4");
   end

   logic [NUM_CH-1:0] synced;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_sync
      ch_sync #(
         .STAGES(SYNC_STAGES)
      ) u_ch_sync (
         .clk_i(clk),
         .rst_i(rst),
         .d_i  (ch_in[c]),
         .q_o  (synced[c])
      );
   end

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    hist_q, hist_d;
   logic            done_q, done_d;
   logic [W-1:0]    smpl_q, smpl_d;
   logic            vld_q, vld_d;
   logic            ovfl_q, ovfl_d;
   logic            capture;
   logic            wrap;
   logic            ovfl_set;

   always_comb begin
      capture = smpl_en & en;
      wrap    = (cnt_q == CntMax);

      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (capture) begin
         cnt_d = wrap ? '0 : cnt_q + CntW'(1);
      end

      // Newest sample enters at the top so age index 0 ends up in the low bits.
      hist_d = capture ? {synced, hist_q[W-1:NUM_CH]} : hist_q;
      done_d = capture & wrap;

      smpl_d   = smpl_q;
      vld_d    = vld_q;
      ovfl_set = 1'b0;
      if (done_q) begin
         if (!vld_q || smpl_rdy) begin
            smpl_d = hist_q;
            vld_d  = 1'b1;
         end else begin
            ovfl_set = 1'b1;
         end
      end else if (vld_q && smpl_rdy) begin
         vld_d = 1'b0;
      end

      if (ovfl_set) begin
         ovfl_d = 1'b1;
      end else if (clr_ovfl) begin
         ovfl_d = 1'b0;
      end else begin
         ovfl_d = ovfl_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         hist_q <= '0;
         done_q <= 1'b0;
         smpl_q <= '0;
         vld_q  <= 1'b0;
         ovfl_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hist_q <= hist_d;
         done_q <= done_d;
         smpl_q <= smpl_d;
         vld_q  <= vld_d;
         ovfl_q <= ovfl_d;
      end
   end

   assign smpl     = smpl_q;
   assign smpl_vld = vld_q;
   assign ovfl     = ovfl_q;

endmodule
